var_shift_seq: RTL

Parametrised multi-cycle variable shifter, successor to the fixed 32-bit variable shift register. Accepts one operand, shift amount, direction and mode per transaction over a valid/ready handshake. Shifts by up to STEP bits per enabled cycle, then presents the result until the consumer accepts it. Sits between operand sources and datapath consumers that can tolerate variable latency in exchange for small area.

---
 rtl/var_shift_pkg.sv | 17 +
 rtl/var_shift_step.sv | 43 ++++
 rtl/var_shift_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/var_shift_pkg.sv
// Shared constants for the multi-cycle variable shifter: mode, direction and FSM state encodings.
package var_shift_pkg;

  localparam logic [1:0] MODE_LOG   = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/var_shift_step.sv
// Combinational single-step shifter moving data by 0..STEP bits; zero latency, no flow control.
module var_shift_step
  import var_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_data
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    w_back;
  logic [WIDTH-1:0] w_sra;

  // Complementary shift for rotation; a shift by WIDTH yields zero, so amt=0 needs no special case
  assign w_back = CW'(WIDTH) - CW'(i_amt);
  assign w_sra  = $signed(i_data) >>> i_amt;

  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_ROT: begin
        if (i_dir == DIR_RIGHT) o_data = (i_data >> i_amt) | (i_data << w_back);
        else                    o_data = (i_data << i_amt) | (i_data >> w_back);
      end
      MODE_ARITH: begin
        if (i_dir == DIR_RIGHT) o_data = w_sra;
        else                    o_data = i_data << i_amt;
      end
      default: begin
        if (i_dir == DIR_RIGHT) o_data = i_data >> i_amt;
        else                    o_data = i_data << i_amt;
      end
    endcase
  end

endmodule

// File: rtl/var_shift_seq.sv
// Multi-cycle variable shifter: up to STEP bits per enabled cycle, latency ceil(eff/STEP)+1 with en high.
// Accepts only in IDLE; holds the result in DONE until out_ready.
module var_shift_seq
  import var_shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               dir,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int AMT_W = $clog2(STEP + 1);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_data, w_step_data;
  logic [SHIFT_W-1:0] r_rem, w_eff, w_rem_nxt;
  logic [AMT_W-1:0]   w_amt;
  logic               r_dir;
  logic [1:0]         r_mode;
  logic               r_out_valid, r_busy;

  // Rotation wraps modulo WIDTH; the other modes saturate at WIDTH
  always_comb begin
    w_eff = shift;
    if (mode == MODE_ROT) w_eff = shift & SHIFT_W'(WIDTH - 1);
    else if (shift > SHIFT_W'(WIDTH)) w_eff = SHIFT_W'(WIDTH);
  end

  assign w_amt     = (r_rem > SHIFT_W'(STEP)) ? AMT_W'(STEP) : r_rem[AMT_W-1:0];
  assign w_rem_nxt = r_rem - SHIFT_W'(w_amt);

  var_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .i_data (r_data),
    .i_amt  (w_amt),
    .i_dir  (r_dir),
    .i_mode (r_mode),
    .o_data (w_step_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = (w_eff == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (en && (w_rem_nxt == '0)) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_data      <= '0;
      r_rem       <= '0;
      r_dir       <= DIR_LEFT;
      r_mode      <= MODE_LOG;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt == ST_SHIFT);
      if ((r_state == ST_IDLE) && in_valid) begin
        r_data <= in;
        r_rem  <= w_eff;
        r_dir  <= dir;
        r_mode <= mode;
      end else if ((r_state == ST_SHIFT) && en) begin
        r_data <= w_step_data;
        r_rem  <= w_rem_nxt;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign q         = r_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule
